yutorina_if_stage: RTL

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC. Fetches one 32-bit instruction per access through a req/grant/strobe/ready bus master port.
- Presents if_pc, if_insn and active-low valid if_en_ to decode.
- Handles stall, load hazard, branch redirect, flush-to-new_pc, and a 1-entry skid buffer so a read completing under stall is never lost.

---
 rtl/yutorina_if_stage_if.sv | 24 ++
 rtl/yutorina_if_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/yutorina_if_stage_if.sv
// rtl/yutorina_if_stage_if.sv - fetch bus: active-low req/grant/strobe/ready, read-only data
// master side is the fetch stage, slave side is the memory/arbiter.
interface yutorina_if_stage_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              bus_req_;
  logic              bus_grnt_;
  logic              bus_as_;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  modport master (
    output bus_req_, bus_as_, bus_rw, bus_addr,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  modport slave (
    input  bus_req_, bus_as_, bus_rw, bus_addr,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );
endinterface

// File: rtl/yutorina_if_stage.sv
// rtl/yutorina_if_stage.sv - instruction fetch stage with PC, bus master, skid buffer
// Decode outputs are fully registered; bus strobe/request are gated by rst so reset aborts at once.
module yutorina_if_stage #(
  parameter int                ADDR_W   = 30,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_INSN = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              ld_haz,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  yutorina_if_stage_if.master bus,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_en_
);

  typedef enum logic {S_REQ = 1'b0, S_ACCESS = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_if_pc;
  logic [DATA_W-1:0] r_if_insn;
  logic              r_if_en_n;
  logic              r_skid_vld;
  logic [ADDR_W-1:0] r_skid_pc;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_discard;

  logic              w_hold;
  logic              w_req_n;
  logic              w_as_n;
  logic [ADDR_W-1:0] w_addr;
  logic              w_rdy;
  logic              w_cmp;
  logic              w_outstanding;
  logic [ADDR_W-1:0] w_pc_next;

  assign w_hold = stall | ld_haz;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: grant is held across accesses; losing it returns to REQ.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_REQ:    if (!bus.bus_grnt_) w_next = S_ACCESS;
      S_ACCESS: if (bus.bus_grnt_)  w_next = S_REQ;
      default:  w_next = S_REQ;
    endcase
  end

  // Bus outputs; the strobe stays off while the skid holds an undelivered word.
  always_comb begin
    w_req_n = 1'b1;
    w_as_n  = 1'b1;
    w_addr  = '0;
    if (!rst) begin
      case (r_state)
        S_REQ: begin
          w_req_n = 1'b0;
        end
        S_ACCESS: begin
          w_req_n = 1'b0;
          w_addr  = r_pc;
          if (!bus.bus_grnt_ && !r_skid_vld) w_as_n = 1'b0;
        end
        default: begin
          w_req_n = 1'b1;
        end
      endcase
    end
  end

  assign bus.bus_req_ = w_req_n;
  assign bus.bus_as_  = w_as_n;
  assign bus.bus_rw   = 1'b1;
  assign bus.bus_addr = w_addr;

  assign w_rdy         = !w_as_n && !bus.bus_rdy_;
  assign w_cmp         = w_rdy && !r_discard;
  assign w_outstanding = !w_as_n && bus.bus_rdy_;
  assign w_pc_next     = br_taken ? br_addr : (r_pc + PC_ONE);

  // PC, skid buffer, discard flag and decode-facing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_if_pc     <= '0;
      r_if_insn   <= NOP_INSN;
      r_if_en_n   <= 1'b1;
      r_skid_vld  <= 1'b0;
      r_skid_pc   <= '0;
      r_skid_data <= '0;
      r_discard   <= 1'b0;
    end else if (flush) begin
      r_pc       <= new_pc;
      r_if_en_n  <= 1'b1;
      r_if_insn  <= NOP_INSN;
      r_skid_vld <= 1'b0;
      // An access already on the bus must have its late ready dropped.
      r_discard  <= w_outstanding | (r_discard & ~w_rdy);
    end else begin
      if (w_rdy) r_discard <= 1'b0;
      if (w_cmp) r_pc <= w_pc_next;
      if (w_hold) begin
        if (w_cmp) begin
          r_skid_vld  <= 1'b1;
          r_skid_pc   <= r_pc;
          r_skid_data <= bus.bus_rd_data;
        end
      end else if (r_skid_vld) begin
        r_if_pc    <= r_skid_pc;
        r_if_insn  <= r_skid_data;
        r_if_en_n  <= 1'b0;
        r_skid_vld <= 1'b0;
      end else if (w_cmp) begin
        r_if_pc   <= r_pc;
        r_if_insn <= bus.bus_rd_data;
        r_if_en_n <= 1'b0;
      end else begin
        r_if_insn <= NOP_INSN;
        r_if_en_n <= 1'b1;
      end
    end
  end

  assign if_pc   = r_if_pc;
  assign if_insn = r_if_insn;
  assign if_en_  = r_if_en_n;

endmodule
